// File: rtl/snn_step_scheduler_pkg.sv
// Shared definitions for the timestep scheduler and the neuron update datapath.
package snn_step_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HID  = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int N_HIDDEN_DEF = 8;
    localparam int N_OUT_DEF    = 2;
    localparam int IDX_W        = 3;

    localparam logic LAYER_HID = 1'b0;
    localparam logic LAYER_OUT = 1'b1;

endpackage

// File: rtl/snn_step_scheduler_flag_sync.sv
// Multi-flop synchroniser for an SPI-domain level flag, with change detect
// against the previous synchronised value.
module snn_step_scheduler_flag_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic changed
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q       = chain[STAGES-1];
    assign changed = q ^ prev;

endmodule

// File: rtl/snn_step_scheduler.sv
// Runs one network timestep per SPI spike frame: latch the spike byte, then
// sweep the hidden layer and the output layer one neuron per cycle.
module snn_step_scheduler
    import snn_step_scheduler_pkg::*;
#(
    parameter int N_HIDDEN    = N_HIDDEN_DEF,
    parameter int N_OUT       = N_OUT_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_div_ready_in,
    input  logic             input_spike_ready_in,
    input  logic [7:0]       input_spikes_in,
    output logic [7:0]       spikes_latched,
    output logic             neuron_en,
    output logic             layer_sel,
    output logic [2:0]       neuron_idx,
    output logic             busy,
    output logic             step_done,
    output logic             overrun,
    output logic [CNT_W-1:0] step_count
);

    logic div_ready;
    logic spike_flag;
    logic ev;
    logic ev_gated;

    snn_step_scheduler_flag_sync #(.STAGES(SYNC_STAGES)) u_div_sync (
        .clk     (clk),
        .reset   (reset),
        .d       (clk_div_ready_in),
        .q       (div_ready),
        .changed ()
    );

    snn_step_scheduler_flag_sync #(.STAGES(SYNC_STAGES)) u_spike_sync (
        .clk     (clk),
        .reset   (reset),
        .d       (input_spike_ready_in),
        .q       (spike_flag),
        .changed (ev)
    );

    // Frames seen before the clock divider is configured are discarded outright.
    assign ev_gated = ev & div_ready;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             overrun_d;
    logic             sweep_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        overrun_d = overrun;
        case (state_q)
            ST_IDLE: begin
                if (ev_gated || (pending_q && div_ready)) begin
                    state_d   = ST_LOAD;
                    // A fresh frame coinciding with a pended launch becomes the new pending one.
                    pending_d = pending_q && ev_gated;
                end
            end
            ST_LOAD: begin
                state_d = ST_HID;
                idx_d   = '0;
            end
            ST_HID: begin
                if (idx_q == IDX_W'(N_HIDDEN - 1)) begin
                    state_d = ST_OUT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (idx_q == IDX_W'(N_OUT - 1)) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        if (state_q != ST_IDLE && ev_gated) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        sweep_d = (state_d == ST_HID) || (state_d == ST_OUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            pending_q      <= 1'b0;
            overrun        <= 1'b0;
            spikes_latched <= '0;
            neuron_en      <= 1'b0;
            layer_sel      <= LAYER_HID;
            neuron_idx     <= '0;
            busy           <= 1'b0;
            step_done      <= 1'b0;
            step_count     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            overrun    <= overrun_d;
            neuron_en  <= sweep_d;
            layer_sel  <= (state_d == ST_OUT) ? LAYER_OUT : LAYER_HID;
            neuron_idx <= sweep_d ? idx_d : '0;
            busy       <= (state_d != ST_IDLE);
            step_done  <= (state_d == ST_DONE);
            if (state_q == ST_LOAD) begin
                spikes_latched <= input_spikes_in;
            end
            if (state_d == ST_DONE) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler: single steps, gating, pending,
// overrun, reset mid-step and step counter wrap.
module tb_snn_step_scheduler;

    logic       clk;
    logic       reset;
    logic       clk_div_ready_in;
    logic       input_spike_ready_in;
    logic [7:0] input_spikes_in;
    logic [7:0] spikes_latched;
    logic       neuron_en;
    logic       layer_sel;
    logic [2:0] neuron_idx;
    logic       busy;
    logic       step_done;
    logic       overrun;
    logic [7:0] step_count;

    int         vectors = 0;
    int         miscompares = 0;
    int         done_seen = 0;
    logic [7:0] exp_count = 8'd0;

    snn_step_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
        .clk_div_ready_in     (clk_div_ready_in),
        .input_spike_ready_in (input_spike_ready_in),
        .input_spikes_in      (input_spikes_in),
        .spikes_latched       (spikes_latched),
        .neuron_en            (neuron_en),
        .layer_sel            (layer_sel),
        .neuron_idx           (neuron_idx),
        .busy                 (busy),
        .step_done            (step_done),
        .overrun              (overrun),
        .step_count           (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (step_done === 1'b1) done_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed no finish, expected finish before 1ms");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic toggle_flag();
        input_spike_ready_in = ~input_spike_ready_in;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_spikes"}, 32'(spikes_latched), 32'h0);
        check({tag, "_en"},     32'(neuron_en),      32'h0);
        check({tag, "_layer"},  32'(layer_sel),      32'h0);
        check({tag, "_idx"},    32'(neuron_idx),     32'h0);
        check({tag, "_busy"},   32'(busy),           32'h0);
        check({tag, "_done"},   32'(step_done),      32'h0);
        check({tag, "_ovr"},    32'(overrun),        32'h0);
        check({tag, "_count"},  32'(step_count),     32'h0);
    endtask

    // Toggle the frame flag now and walk the 15 cycles that follow.
    // Cycle 3 is LOAD, 4..11 hidden sweep, 12..13 output sweep, 14 DONE, 15 IDLE.
    task automatic run_step(input logic [7:0] sp);
        logic       e_en;
        logic       e_layer;
        logic [2:0] e_idx;
        input_spikes_in = sp;
        toggle_flag();
        for (int k = 1; k <= 15; k++) begin
            tick();
            e_en    = (k >= 4) && (k <= 13);
            e_layer = (k >= 12) && (k <= 13);
            e_idx   = !e_en ? 3'd0 : (k <= 11) ? 3'(k - 4) : 3'(k - 12);
            check($sformatf("step_en_c%0d", k),    32'(neuron_en), 32'(e_en));
            check($sformatf("step_layer_c%0d", k), 32'(layer_sel), 32'(e_layer));
            check($sformatf("step_idx_c%0d", k),   32'(neuron_idx), 32'(e_idx));
            check($sformatf("step_busy_c%0d", k),  32'(busy), 32'((k >= 3) && (k <= 14)));
            check($sformatf("step_done_c%0d", k),  32'(step_done), 32'(k == 14));
            if (k >= 4) check($sformatf("step_spikes_c%0d", k), 32'(spikes_latched), 32'(sp));
            if (k == 14) begin
                exp_count = exp_count + 8'd1;
                check("step_count", 32'(step_count), 32'(exp_count));
            end
        end
    endtask

    initial begin
        int base;
        bit got;

        reset                = 1'b1;
        clk_div_ready_in     = 1'b0;
        input_spike_ready_in = 1'b0;
        input_spikes_in      = 8'h00;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        clk_div_ready_in = 1'b1;
        repeat (4) tick();

        // Single step with 0xA5.
        run_step(8'hA5);
        check("single_ovr", 32'(overrun), 32'h0);
        tick();

        // Divider not ready: frame is dropped and not pended.
        clk_div_ready_in = 1'b0;
        repeat (4) tick();
        base = done_seen;
        toggle_flag();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("gated_busy", 32'(busy), 32'h0);
        end
        clk_div_ready_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("gated_after_busy", 32'(busy), 32'h0);
        end
        check("gated_done_count", 32'(done_seen), 32'(base));
        check("gated_count", 32'(step_count), 32'(exp_count));

        // Second frame during the 4th hidden cycle is pended and runs back-to-back.
        toggle_flag();
        repeat (7) tick();
        check("pend_pos_idx", 32'(neuron_idx), 32'h3);
        toggle_flag();
        repeat (7) tick();
        check("pend_done1", 32'(step_done), 32'h1);
        tick();
        check("pend_idle_busy", 32'(busy), 32'h0);
        check("pend_idle_done", 32'(step_done), 32'h0);
        tick();
        check("pend_load_busy", 32'(busy), 32'h1);
        check("pend_load_en", 32'(neuron_en), 32'h0);
        repeat (11) tick();
        check("pend_done2", 32'(step_done), 32'h1);
        exp_count = exp_count + 8'd2;
        check("pend_count", 32'(step_count), 32'(exp_count));
        check("pend_ovr", 32'(overrun), 32'h0);
        repeat (2) tick();

        // Three frames in one step: two steps run, overrun sticks.
        base = done_seen;
        toggle_flag();
        repeat (5) tick();
        toggle_flag();
        repeat (3) tick();
        toggle_flag();
        repeat (4) tick();
        check("ovr_set", 32'(overrun), 32'h1);
        repeat (15) tick();
        check("ovr_done2", 32'(step_done), 32'h1);
        exp_count = exp_count + 8'd2;
        check("ovr_count", 32'(step_count), 32'(exp_count));
        repeat (6) tick();
        check("ovr_two_steps", 32'(done_seen - base), 32'h2);
        check("ovr_idle_busy", 32'(busy), 32'h0);
        run_step(8'h3C);
        check("ovr_sticky", 32'(overrun), 32'h1);
        tick();

        // Reset during the 5th hidden cycle.
        toggle_flag();
        input_spikes_in = 8'h5A;
        repeat (8) tick();
        check("rst_pos_idx", 32'(neuron_idx), 32'h4);
        base = done_seen;
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        input_spike_ready_in = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        exp_count = 8'd0;
        repeat (6) tick();
        check("rst_after_busy", 32'(busy), 32'h0);
        check("rst_after_count", 32'(step_count), 32'h0);
        check("rst_no_done", 32'(done_seen), 32'(base));
        run_step(8'hC3);
        check("rst_ovr_clear", 32'(overrun), 32'h0);
        tick();

        // Counter wrap: 255 more steps brings the total to 256.
        for (int s = 0; s < 255; s++) begin
            toggle_flag();
            got = 1'b0;
            for (int k = 0; k < 30 && !got; k++) begin
                tick();
                if (step_done === 1'b1) got = 1'b1;
            end
            check("wrap_step_done_seen", 32'(got), 32'h1);
            exp_count = exp_count + 8'd1;
            check("wrap_count", 32'(step_count), 32'(exp_count));
            repeat (2) tick();
        end
        check("wrap_zero", 32'(step_count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
